alu_result_history: RTL
=======================

# alu_result_history

Downstream stage of the accumulate ALU. It captures each 8-bit ALU result when the operator presses the accumulate key, and keeps the last DEPTH results in a circular history. The operator can browse the history manually or let it auto-scroll; the selected entry and its age drive the HEX/LEDR display path.

## Interface
- DEPTH, 8 — history entries; must be a power of 2, ≥2.
- WIDTH, 8 — result width, matching the ALU output.
- SCROLL_DIV, 50_000_000 — clock cycles per auto-scroll step; must be ≥2.
- clock  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low. Clock is `clock`.
- capture  in  1  asynchronous level (accumulate key, active-high after board inversion). A rising edge stores `result`.
- result  in  WIDTH  combinational ALU output.
- browse_up  in  1  asynchronous level. A rising edge selects an older entry.
- browse_down  in  1  asynchronous level. A rising edge selects a newer entry.
- auto_scroll  in  1  level. Enables timed stepping through the history.
- clear  in  1  asynchronous level. A rising edge empties the history.
- view_data  out  WIDTH  selected entry, or 0 when empty.
- view_age  out  log2(DEPTH)  age of the selected entry; 0 is the newest.
- count  out  log2(DEPTH)+1  number of valid entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Every asynchronous input passes through a 2-flop synchronizer and a rising-edge detector. The result is a one-cycle pulse: cap_p, up_p, dn_p, clr_p.
- Storage: memory mem[DEPTH], write pointer wr_ptr, count, and age register `age`.
- Read address = (wr_ptr − 1 − age) mod DEPTH.
- view_data = empty ? 0 : mem[read address].
- cap_p:
  - mem[wr_ptr] ← result.
  - wr_ptr ← wr_ptr+1, wrapping modulo DEPTH.
  - count ← min(count+1, DEPTH). When full, the oldest entry is overwritten.
  - age ← 0.
  - The divider counter clears.
- up_p: age ← min(age+1, count−1). No effect when empty.
- dn_p: age ← max(age−1, 0).
- up_p and dn_p in the same cycle: age unchanged.
- Auto-scroll:
  - While auto_scroll=1 and count>1, the divider counts 0..SCROLL_DIV−1.
  - On the terminal count, age ← (age == count−1) ? 0 : age+1.
  - When auto_scroll=0 or count≤1, the divider is held at 0.
- clr_p: wr_ptr, count, age and the divider go to 0. Memory contents are left stale; they are unreachable because count=0.
- Priority, highest first: reset > clr_p > cap_p > auto-step > up_p/dn_p.
- Arithmetic:
  - Pointer arithmetic is unsigned and wraps at DEPTH.
  - count never exceeds DEPTH.
  - age is always < max(count,1).

## Timing
- Reset (reset_n=0 at a rising edge):
  - wr_ptr, count, age, divider and all synchronizer/edge flops go to 0.
  - Outputs: view_data=0, view_age=0, count=0, empty=1, full=0.
  - Memory is not reset.
- Input latency:
  - An input first sampled high at edge k produces its pulse during cycle k+1..k+2.
  - The state update commits at edge k+2.
  - Outputs reflect the update immediately after edge k+2. view_data is combinational from registered state.
- Result sampling: `result` is sampled at the commit edge (k+2). By then the ALU register has latched on the same key press, so the stored value is the post-press ALU output.
- A held input produces exactly one pulse. A new pulse requires the input to be sampled low first.
- Reset asserted mid-operation aborts any pending pulse: edge flops are cleared, so no commit occurs after reset releases.
- Auto-scroll step period is exactly SCROLL_DIV cycles from the divider's last clear.

## Structure
- Constants DEPTH, WIDTH and SCROLL_DIV defaults live in the shared lab header, alongside the ALU width definitions.
- One sub-module: `edge_sync` (2-flop synchronizer plus rising-edge pulse, synchronous active-low reset), instantiated four times.
- Top-level wiring connects:
  - result to the ALU output;
  - capture to the same key that clocks the ALU register;
  - view_data nibbles to the existing hex decoders.

## Test plan
- Reset, then capture results 0x11, 0x22, 0x33 → count=3; view_data=0x33 with view_age=0; after two browse_up presses, view_data=0x11 and view_age=2; a third browse_up leaves age at 2.
- Capture 10 results 0x01..0x0A with DEPTH=8 → full=1, count=8; newest=0x0A, oldest (age 7)=0x03; wr_ptr wrapped to 2.
- Set SCROLL_DIV=4, capture 3 results, set auto_scroll=1 → view_age steps 0,1,2,0 every 4 cycles; a capture mid-scroll resets age to 0 and restarts the divider.
- Assert clear after 5 captures → count=0, empty=1, view_data=0; the next capture of 0x5A gives count=1 and view_data=0x5A.
- Raise browse_up and capture in the same cycle with count=4, age=1 → after commit, age=0 and count=5 (capture wins). Raise browse_up and browse_down together → age unchanged.
- Hold capture high for 100 cycles → exactly one entry added. Assert reset_n=0 one cycle after capture rises → no entry is written, and all outputs read their reset values.

Source files
------------

// File: rtl/alu_result_history_pkg.sv
// Shared constants and helpers for the ALU result history.
package alu_result_history_pkg;

  // Default sizing, matching the 8-bit accumulate ALU on the lab board.
  localparam int unsigned DefaultDepth     = 8;
  localparam int unsigned DefaultWidth     = 8;
  localparam int unsigned DefaultScrollDiv = 50_000_000;

  // The single state update that wins in a given cycle.
  typedef enum logic [2:0] {
    ActNone,
    ActClear,
    ActCapture,
    ActStep,
    ActBrowse
  } hist_act_e;

  // Resolve simultaneous requests: clear > capture > auto-step > browse.
  function automatic hist_act_e pick_act(input logic clr, input logic cap,
                                         input logic step, input logic browse);
    if (clr) begin
      return ActClear;
    end else if (cap) begin
      return ActCapture;
    end else if (step) begin
      return ActStep;
    end else if (browse) begin
      return ActBrowse;
    end
    return ActNone;
  endfunction

endpackage

// File: rtl/alu_result_history_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Emits a single-cycle pulse per low-to-high transition of an asynchronous level.
module edge_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic level_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronizer chain and previous-value flop, all cleared on reset so a
  // pending edge is dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], level_i};
      prev_q <= sync_q[1];
    end
  end

  // Pulse while the synchronized level is high but was low last cycle.
  always_comb begin
    pulse_o = sync_q[1] & ~prev_q;
  end

endmodule

// File: rtl/alu_result_history.sv
// Circular history of captured ALU results with manual browse and auto-scroll.
module alu_result_history
  import alu_result_history_pkg::*;
#(
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned SCROLL_DIV = DefaultScrollDiv
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       capture,
  input  logic [WIDTH-1:0]           result,
  input  logic                       browse_up,
  input  logic                       browse_down,
  input  logic                       auto_scroll,
  input  logic                       clear,
  output logic [WIDTH-1:0]           view_data,
  output logic [$clog2(DEPTH)-1:0]   view_age,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = $clog2(SCROLL_DIV);

  localparam logic [AW:0]   CountMax  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CountOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] AgeOne    = AW'(1);
  localparam logic [DW-1:0] DivLast   = DW'(SCROLL_DIV - 1);
  localparam logic [DW-1:0] DivOne    = DW'(1);

  logic cap_p, up_p, dn_p, clr_p;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    age_q, age_d;
  logic [DW-1:0]    div_q, div_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] rd_addr;
  logic [AW:0]   age_ext;
  logic [AW:0]   count_m1;
  logic          div_run;
  logic          step;
  logic          browse;
  logic          is_empty;
  hist_act_e     act;

  edge_sync u_sync_cap (
    .clock   (clock),
    .reset_n (reset_n),
    .level_i (capture),
    .pulse_o (cap_p)
  );

  edge_sync u_sync_up (
    .clock   (clock),
    .reset_n (reset_n),
    .level_i (browse_up),
    .pulse_o (up_p)
  );

  edge_sync u_sync_dn (
    .clock   (clock),
    .reset_n (reset_n),
    .level_i (browse_down),
    .pulse_o (dn_p)
  );

  edge_sync u_sync_clr (
    .clock   (clock),
    .reset_n (reset_n),
    .level_i (clear),
    .pulse_o (clr_p)
  );

  // Decode which single update applies this cycle and compute next state.
  always_comb begin
    is_empty = (count_q == '0);
    age_ext  = {1'b0, age_q};
    count_m1 = count_q - CountOne;
    div_run  = auto_scroll && (count_q > CountOne);
    step     = div_run && (div_q == DivLast);
    // Opposing browse pulses cancel out.
    browse   = up_p ^ dn_p;
    act      = pick_act(clr_p, cap_p, step, browse);

    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    age_d    = age_q;
    if (!div_run || step) begin
      div_d = '0;
    end else begin
      div_d = div_q + DivOne;
    end

    unique case (act)
      ActClear: begin
        wr_ptr_d = '0;
        count_d  = '0;
        age_d    = '0;
        div_d    = '0;
      end
      ActCapture: begin
        wr_ptr_d = wr_ptr_q + AgeOne;
        count_d  = (count_q == CountMax) ? count_q : count_q + CountOne;
        age_d    = '0;
        div_d    = '0;
      end
      ActStep: begin
        age_d = (age_ext == count_m1) ? '0 : age_q + AgeOne;
      end
      ActBrowse: begin
        if (up_p) begin
          if (!is_empty && (age_ext < count_m1)) begin
            age_d = age_q + AgeOne;
          end
        end else if (age_q != '0) begin
          age_d = age_q - AgeOne;
        end
      end
      default: begin
      end
    endcase
  end

  // Pointer, occupancy, selection and divider registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      div_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      div_q    <= div_d;
    end
  end

  // History storage; not reset, stale entries are hidden by count.
  always_ff @(posedge clock) begin
    if (reset_n && (act == ActCapture)) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

  // Newest entry sits just below the write pointer; age walks back from it.
  always_comb begin
    rd_addr   = wr_ptr_q - AgeOne - age_q;
    view_data = is_empty ? '0 : mem_q[rd_addr];
  end

  assign view_age = age_q;
  assign count    = count_q;
  assign full     = (count_q == CountMax);
  assign empty    = (count_q == '0);

  a_count_max: assert property (@(posedge clock) disable iff (!reset_n)
    count_q <= CountMax);

  a_age_valid: assert property (@(posedge clock) disable iff (!reset_n)
    (count_q == '0) ? (age_q == '0) : (age_ext < count_q));

endmodule
